// File: rtl/sprite_pal_pkg.sv
// Shared types and constants for the sprite palette lookup.
// LUT_LAT is 3 when SPRITE_PAL_FADE_EN is defined (extra fade stage), else 2.
package sprite_pal_pkg;

   localparam int DEF_COLOR_W = 8;

   typedef struct packed {
      logic [DEF_COLOR_W-1:0] r;
      logic [DEF_COLOR_W-1:0] g;
      logic [DEF_COLOR_W-1:0] b;
   } rgb_t;

   localparam logic [23:0] KEY_RGB_DEF = 24'hFE06FF;

`ifdef SPRITE_PAL_FADE_EN
   localparam int LUT_LAT = 3;
`else
   localparam int LUT_LAT = 2;
`endif

   function automatic int pal_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/palette_bank.sv
// Double-buffered palette storage: bus writes land in shadow, and a pending
// commit copies every shadow entry into active on the next frame_start.
module palette_bank #(
   parameter int IDX_W   = 4,
   parameter int NUM_PAL = 4,
   parameter int PAL_W   = 2,
   parameter int RGB_W   = 24,
   parameter logic [RGB_W-1:0] KEY = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [PAL_W-1:0] wr_pal,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [RGB_W-1:0] wr_rgb,
   input  logic             commit,
   input  logic             frame_start,
   input  logic [PAL_W-1:0] rd_pal,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [RGB_W-1:0] rd_rgb,
   output logic             commit_pending
);

   localparam int DEPTH   = 1 << IDX_W;
   localparam int ENTRIES = NUM_PAL * DEPTH;
   localparam int ADDR_W  = PAL_W + IDX_W;

   logic              pending_q, pending_d;
   logic              copy;
   logic              wr_ok;
   logic [ADDR_W-1:0] wr_addr;
   logic [RGB_W-1:0]  active_rd [ENTRIES];

   always_comb begin
      wr_addr   = {wr_pal, wr_idx};
      wr_ok     = wr_en && (int'(wr_pal) < NUM_PAL);
      copy      = frame_start && pending_q;
      pending_d = pending_q;
      if (copy)
         pending_d = 1'b0;
      // A commit arriving with the copy re-arms pending for the next frame.
      if (commit)
         pending_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pending_q <= 1'b0;
      else
         pending_q <= pending_d;
   end

   genvar gi;
   generate
      for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
         logic [RGB_W-1:0] shadow_q, shadow_d;
         logic [RGB_W-1:0] active_q, active_d;

         // The copy reads shadow_q, so a same-cycle write is not carried over.
         always_comb begin
            shadow_d = shadow_q;
            if (wr_ok && (wr_addr == ADDR_W'(gi)))
               shadow_d = wr_rgb;
            active_d = copy ? shadow_q : active_q;
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               shadow_q <= KEY;
               active_q <= KEY;
            end else begin
               shadow_q <= shadow_d;
               active_q <= active_d;
            end
         end

         assign active_rd[gi] = active_q;
      end
   endgenerate

   always_comb begin
      rd_rgb = KEY;
      if (int'(rd_pal) < NUM_PAL)
         rd_rgb = active_rd[{rd_pal, rd_idx}];
   end

   assign commit_pending = pending_q;

endmodule

// File: rtl/sprite_palette_lut.sv
// Pipelined sprite palette lookup with chroma-key transparency.
// Define SPRITE_PAL_FADE_EN to add a brightness-fade third stage.
module sprite_palette_lut
   import sprite_pal_pkg::*;
#(
   parameter int IDX_W   = 4,
   parameter int NUM_PAL = 4,
   parameter int COLOR_W = 8,
   parameter logic [23:0] KEY_RGB = KEY_RGB_DEF,
   localparam int PAL_W  = pal_width(NUM_PAL)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 pix_valid,
   input  logic [PAL_W-1:0]     pix_pal,
   input  logic [IDX_W-1:0]     pix_idx,
   input  logic [2:0]           fade_lvl,
   input  logic                 wr_en,
   input  logic [PAL_W-1:0]     wr_pal,
   input  logic [IDX_W-1:0]     wr_idx,
   input  logic [3*COLOR_W-1:0] wr_rgb,
   input  logic                 commit,
   input  logic                 frame_start,
   output logic                 commit_pending,
   output logic                 out_valid,
   output logic [COLOR_W-1:0]   red,
   output logic [COLOR_W-1:0]   green,
   output logic [COLOR_W-1:0]   blue,
   output logic                 transparent
);

   localparam int RGB_W = 3 * COLOR_W;
   localparam logic [7:0] KEY_R8 = KEY_RGB[23:16];
   localparam logic [7:0] KEY_G8 = KEY_RGB[15:8];
   localparam logic [7:0] KEY_B8 = KEY_RGB[7:0];
   localparam logic [RGB_W-1:0] KEY = {COLOR_W'(KEY_R8), COLOR_W'(KEY_G8), COLOR_W'(KEY_B8)};

   logic             s1_valid_q, s1_valid_d;
   logic [PAL_W-1:0] s1_pal_q, s1_pal_d;
   logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
   logic             s2_valid_q, s2_valid_d;
   logic [RGB_W-1:0] s2_rgb_q, s2_rgb_d;
   logic             s2_transp_q, s2_transp_d;
   logic [RGB_W-1:0] rd_rgb;

   palette_bank #(
      .IDX_W(IDX_W), .NUM_PAL(NUM_PAL), .PAL_W(PAL_W), .RGB_W(RGB_W), .KEY(KEY)
   ) u_bank (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_pal(wr_pal), .wr_idx(wr_idx), .wr_rgb(wr_rgb),
      .commit(commit), .frame_start(frame_start),
      .rd_pal(s1_pal_q), .rd_idx(s1_idx_q), .rd_rgb(rd_rgb),
      .commit_pending(commit_pending)
   );

   // Result registers hold their last value while no lookup is completing.
   always_comb begin
      s1_valid_d  = pix_valid;
      s1_pal_d    = pix_pal;
      s1_idx_d    = pix_idx;
      s2_valid_d  = s1_valid_q;
      s2_rgb_d    = s2_rgb_q;
      s2_transp_d = s2_transp_q;
      if (s1_valid_q) begin
         s2_rgb_d    = rd_rgb;
         s2_transp_d = (int'(s1_pal_q) >= NUM_PAL) || (rd_rgb == KEY);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_pal_q    <= '0;
         s1_idx_q    <= '0;
         s2_valid_q  <= 1'b0;
         s2_rgb_q    <= '0;
         s2_transp_q <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_pal_q    <= s1_pal_d;
         s1_idx_q    <= s1_idx_d;
         s2_valid_q  <= s2_valid_d;
         s2_rgb_q    <= s2_rgb_d;
         s2_transp_q <= s2_transp_d;
      end
   end

`ifdef SPRITE_PAL_FADE_EN
   logic [2:0]       s1_fade_q, s1_fade_d;
   logic [2:0]       s2_fade_q, s2_fade_d;
   logic             s3_valid_q, s3_valid_d;
   logic [RGB_W-1:0] s3_rgb_q, s3_rgb_d;
   logic             s3_transp_q, s3_transp_d;

   function automatic logic [COLOR_W-1:0] fade_ch(input logic [COLOR_W-1:0] c,
                                                   input logic [2:0] lvl);
      logic [COLOR_W+3:0] prod;
      prod = (COLOR_W+4)'(c) * (COLOR_W+4)'(4'd8 - {1'b0, lvl});
      return COLOR_W'(prod >> 3);
   endfunction

   always_comb begin
      s1_fade_d   = fade_lvl;
      s2_fade_d   = s1_valid_q ? s1_fade_q : s2_fade_q;
      s3_valid_d  = s2_valid_q;
      s3_rgb_d    = s3_rgb_q;
      s3_transp_d = s3_transp_q;
      if (s2_valid_q) begin
         s3_rgb_d = {fade_ch(s2_rgb_q[3*COLOR_W-1:2*COLOR_W], s2_fade_q),
                     fade_ch(s2_rgb_q[2*COLOR_W-1:COLOR_W], s2_fade_q),
                     fade_ch(s2_rgb_q[COLOR_W-1:0], s2_fade_q)};
         s3_transp_d = s2_transp_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_fade_q   <= '0;
         s2_fade_q   <= '0;
         s3_valid_q  <= 1'b0;
         s3_rgb_q    <= '0;
         s3_transp_q <= 1'b0;
      end else begin
         s1_fade_q   <= s1_fade_d;
         s2_fade_q   <= s2_fade_d;
         s3_valid_q  <= s3_valid_d;
         s3_rgb_q    <= s3_rgb_d;
         s3_transp_q <= s3_transp_d;
      end
   end

   assign out_valid   = s3_valid_q;
   assign transparent = s3_transp_q;
   assign {red, green, blue} = s3_rgb_q;
`else
   logic unused_fade;
   assign unused_fade = ^fade_lvl;

   assign out_valid   = s2_valid_q;
   assign transparent = s2_transp_q;
   assign {red, green, blue} = s2_rgb_q;
`endif

endmodule

// File: tb/tb_sprite_palette_lut.sv
// Self-checking bench: directed scenarios plus random traffic, compared
// against a table-level reference model of the palette and commit rules.
module tb_sprite_palette_lut;
   import sprite_pal_pkg::*;

   localparam int NUM_PAL = 3;
   localparam int IDX_W   = 4;
   localparam int COLOR_W = 8;
   localparam int PAL_W   = 2;
   localparam logic [23:0] KEY = 24'hFE06FF;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             pix_valid, wr_en, commit, frame_start;
   logic [PAL_W-1:0] pix_pal, wr_pal;
   logic [IDX_W-1:0] pix_idx, wr_idx;
   logic [2:0]       fade_lvl;
   logic [23:0]      wr_rgb;
   logic             commit_pending, out_valid, transparent;
   logic [7:0]       red, green, blue;

   sprite_palette_lut #(
      .IDX_W(IDX_W), .NUM_PAL(NUM_PAL), .COLOR_W(COLOR_W), .KEY_RGB(KEY)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .pix_valid(pix_valid), .pix_pal(pix_pal), .pix_idx(pix_idx), .fade_lvl(fade_lvl),
      .wr_en(wr_en), .wr_pal(wr_pal), .wr_idx(wr_idx), .wr_rgb(wr_rgb),
      .commit(commit), .frame_start(frame_start),
      .commit_pending(commit_pending), .out_valid(out_valid),
      .red(red), .green(green), .blue(blue), .transparent(transparent)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      int          pal;
      int          idx;
      logic [23:0] rgb;
      bit          transp;
   } exp_t;

   logic [23:0] shadow_m [NUM_PAL][16];
   logic [23:0] active_m [NUM_PAL][16];
   bit          pending_m;
   exp_t        exp_q [$];
   logic [23:0] held_rgb;
   bit          held_t;
   int          edge_cnt = 0;
   int          n_checks = 0;
   int          n_pass = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, want, edge_cnt);
   endtask

   function automatic logic [23:0] fade_m(input logic [23:0] c, input int f);
      int r, g, b;
      r = (int'(c[23:16]) * (8 - f)) / 8;
      g = (int'(c[15:8])  * (8 - f)) / 8;
      b = (int'(c[7:0])   * (8 - f)) / 8;
      return {r[7:0], g[7:0], b[7:0]};
   endfunction

   task automatic model_reset();
      for (int p = 0; p < NUM_PAL; p++)
         for (int i = 0; i < 16; i++) begin
            shadow_m[p][i] = KEY;
            active_m[p][i] = KEY;
         end
      pending_m = 0;
      exp_q.delete();
      held_rgb = '0;
      held_t = 0;
   endtask

   task automatic idle();
      pix_valid = 0; pix_pal = '0; pix_idx = '0; fade_lvl = '0;
      wr_en = 0; wr_pal = '0; wr_idx = '0; wr_rgb = '0;
      commit = 0; frame_start = 0;
   endtask

   task automatic look(input int p, input int i, input int f);
      pix_valid = 1; pix_pal = PAL_W'(p); pix_idx = IDX_W'(i); fade_lvl = 3'(f);
   endtask

   task automatic wr(input int p, input int i, input logic [23:0] v);
      wr_en = 1; wr_pal = PAL_W'(p); wr_idx = IDX_W'(i); wr_rgb = v;
   endtask

   // Apply the spec's rules for one clock edge, then check the DUT after it.
   task automatic tick();
      bit   copy;
      exp_t e;
      copy = frame_start && pending_m;
      if (copy)
         active_m = shadow_m;
      if (wr_en && int'(wr_pal) < NUM_PAL)
         shadow_m[wr_pal][wr_idx] = wr_rgb;
      if (copy)
         pending_m = 0;
      if (commit)
         pending_m = 1;
      if (pix_valid) begin
         e.due = edge_cnt + LUT_LAT;
         e.pal = int'(pix_pal);
         e.idx = int'(pix_idx);
         if (e.pal >= NUM_PAL) begin
            e.rgb = KEY;
            e.transp = 1;
         end else begin
            e.rgb = active_m[e.pal][e.idx];
            e.transp = (e.rgb == KEY);
         end
`ifdef SPRITE_PAL_FADE_EN
         e.rgb = fade_m(e.rgb, int'(fade_lvl));
`endif
         exp_q.push_back(e);
      end
      @(posedge clk);
      edge_cnt++;
      @(negedge clk);
      check_val("pending", 32'(commit_pending), 32'(pending_m));
      if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
         e = exp_q.pop_front();
         check_val("out_valid", 32'(out_valid), 32'd1);
         check_val("rgb", 32'({red, green, blue}), 32'(e.rgb));
         check_val("transparent", 32'(transparent), 32'(e.transp));
         held_rgb = e.rgb;
         held_t = e.transp;
         $display("lookup pal=%0d idx=%0d rgb=%06h transparent=%0b",
                  e.pal, e.idx, {red, green, blue}, transparent);
      end else begin
         check_val("idle_valid", 32'(out_valid), 32'd0);
         check_val("hold_rgb", 32'({red, green, blue}), 32'(held_rgb));
         check_val("hold_transparent", 32'(transparent), 32'(held_t));
      end
   endtask

   task automatic ticks(input int n);
      idle();
      for (int k = 0; k < n; k++)
         tick();
   endtask

   task automatic do_reset();
      #2 rst_n = 0;
      #1;
      check_val("rst_valid", 32'(out_valid), 32'd0);
      check_val("rst_rgb", 32'({red, green, blue}), 32'd0);
      check_val("rst_transparent", 32'(transparent), 32'd0);
      check_val("rst_pending", 32'(commit_pending), 32'd0);
      model_reset();
      idle();
      @(posedge clk);
      edge_cnt++;
      @(negedge clk);
      rst_n = 1;
      $display("reset applied at edge %0d", edge_cnt);
   endtask

   initial begin
      idle();
      model_reset();
      do_reset();

      // Lookup straight out of reset returns the key colour.
      look(0, 5, 0); tick(); ticks(3);

      // Committed write becomes visible only after frame_start.
      wr(1, 3, 24'h8F4D2A); commit = 1; tick();
      idle(); look(1, 3, 0); tick(); ticks(2);
      idle(); frame_start = 1; tick();
      idle(); look(1, 3, 0); tick(); ticks(2);

      // Write colliding with the copy cycle stays in shadow only.
      idle(); commit = 1; tick();
      idle(); wr(1, 3, 24'h123456); frame_start = 1; tick();
      idle(); look(1, 3, 0); tick(); ticks(2);
      idle(); commit = 1; tick();
      idle(); frame_start = 1; tick();
      idle(); look(1, 3, 0); tick(); ticks(2);

      // commit and frame_start together with nothing pending: no copy yet.
      idle(); wr(0, 7, 24'h0A0B0C); commit = 1; frame_start = 1; tick();
      idle(); look(0, 7, 0); tick(); ticks(2);
      idle(); frame_start = 1; tick();
      idle(); look(0, 7, 0); tick(); ticks(2);

      // Out-of-range palette: lookup gives key, writes are dropped.
      idle(); look(3, 2, 0); tick();
      idle(); wr(3, 2, 24'h000000); commit = 1; tick();
      idle(); frame_start = 1; tick();
      for (int p = 0; p < 4; p++) begin
         idle(); look(p, 2, 0); tick();
      end
      ticks(3);

      // Fade sample entry.
      idle(); wr(2, 0, 24'hCB6C3D); commit = 1; tick();
      idle(); frame_start = 1; tick();
      idle(); look(2, 0, 4); tick(); ticks(3);

      // Fill palette 1 and stream 16 back-to-back lookups.
      for (int i = 0; i < 16; i++) begin
         idle(); wr(1, i, 24'($urandom)); tick();
      end
      idle(); commit = 1; tick();
      idle(); frame_start = 1; tick();
      for (int i = 0; i < 16; i++) begin
         idle(); look(1, i, int'($urandom_range(0, 7))); tick();
      end
      ticks(3);

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         idle();
         pix_valid   = ($urandom_range(0, 3) != 0);
         pix_pal     = PAL_W'($urandom_range(0, 3));
         pix_idx     = IDX_W'($urandom);
         fade_lvl    = 3'($urandom);
         wr_en       = ($urandom_range(0, 1) != 0);
         wr_pal      = PAL_W'($urandom_range(0, 3));
         wr_idx      = IDX_W'($urandom);
         wr_rgb      = ($urandom_range(0, 7) == 0) ? KEY : 24'($urandom);
         commit      = ($urandom_range(0, 7) == 0);
         frame_start = ($urandom_range(0, 5) == 0);
         tick();
      end
      ticks(4);

      // Reset in the middle of a lookup stream drops everything.
      for (int i = 0; i < 5; i++) begin
         idle(); look(1, i, 0); tick();
      end
      do_reset();
      idle(); look(1, 3, 0); tick(); ticks(4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sprite_palette_lut.md
# sprite_palette_lut

Parametrised, run-time-loadable colour lookup for sprite pixel indices. It holds NUM_PAL palettes of 2^IDX_W RGB entries each, double-buffered so software writes never tear mid-frame. A pipelined lookup returns RGB plus a transparency flag (chroma key). It sits between the sprite ROM readers and the VGA colour mux, replacing the fixed per-sprite palettes.

## Interface
- IDX_W, 4: pixel index width; 2^IDX_W entries per palette
- NUM_PAL, 4: number of palettes (≥1, need not be a power of 2); PAL_W = max(1, $clog2(NUM_PAL))
- COLOR_W, 8: bits per colour channel
- KEY_RGB, 24'hFE06FF: chroma-key colour (COLOR_W=8 form; truncated per channel otherwise)
- Clk  in  1  single clock
- Reset_n  in  1  asynchronous, active-low reset
- pix_valid  in  1  lookup request
- pix_pal  in  PAL_W  palette select
- pix_idx  in  IDX_W  colour index
- fade_lvl  in  3  brightness attenuation (used only with SPRITE_PAL_FADE_EN)
- wr_en  in  1  shadow-table write strobe
- wr_pal  in  PAL_W  write palette
- wr_idx  in  IDX_W  write entry
- wr_rgb  in  3*COLOR_W  {R,G,B}
- commit  in  1  pulse: request shadow→active copy
- frame_start  in  1  pulse at vsync boundary
- commit_pending  out  1  commit requested, not yet applied
- out_valid  out  1  lookup result valid
- red, green, blue  out  COLOR_W each  looked-up colour
- transparent  out  1  result equals KEY_RGB or palette out of range

## Operation
- Two tables: shadow (write-only from bus) and active (read by lookup). Both reset to KEY_RGB in every entry.
- wr_en writes wr_rgb into shadow[wr_pal][wr_idx]; ignored if wr_pal ≥ NUM_PAL.
- commit sets commit_pending. On a frame_start with commit_pending=1, all shadow entries copy into active in that single cycle, and commit_pending clears.
- Shadow write in the same cycle as a copy: the copy uses the pre-write shadow value; the write lands in shadow only.
- commit and frame_start in the same cycle: pending sets; the copy waits for the next frame_start. If pending was already 1, the copy happens and pending stays set.
- Extra commits while pending are absorbed. frame_start without pending does nothing.
- Lookup: stage 1 registers pix_valid/pix_pal/pix_idx; stage 2 reads active, registers RGB and transparent.
- pix_pal ≥ NUM_PAL: output KEY_RGB, transparent=1.
- transparent is computed on the unfaded colour.

## Timing
- Reset (async assert, sync-released use): out_valid=0, red/green/blue=0, transparent=0, commit_pending=0, pipeline valids=0, both tables=KEY_RGB.
- Lookup latency: 2 cycles (3 with fade). Fully pipelined, one lookup per cycle, no backpressure.
- out_valid follows pix_valid delayed by the latency. Data holds its last value when out_valid=0.
- Active-table update is visible to lookups sampled in stage 1 on the copy cycle or later. The stage-2 read in the copy cycle sees the old contents.
- Reset mid-frame: tables return to KEY_RGB, pending is lost, and in-flight lookups are dropped.

## Configuration
- SPRITE_PAL_FADE_EN defined: adds stage 3, where each channel = (c × (8 − fade_lvl)) >> 3, truncated to COLOR_W. fade_lvl is sampled with pix_* in stage 1 and pipelined alongside. fade_lvl=0 passes the colour unchanged. transparent is delayed to stay aligned with the colour. Latency is 3.
- Undefined: fade_lvl is ignored, there is no stage 3, and latency is 2.

## Structure
- Package sprite_pal_pkg: rgb_t struct (r,g,b of COLOR_W), KEY_RGB default constant, fade latency constant (LUT_LAT) selected by the macro.
- Sub-module palette_bank: shadow and active storage, write port, commit/pending logic, copy. Exposes a combinational read of active. The top level holds the lookup pipeline and fade stage.

## Test plan
- After reset, lookup pal 0 idx 5 → out_valid 2 cycles later, RGB=FE06FF, transparent=1, commit_pending=0.
- Write pal1/idx3=0x8F4D2A, commit, then lookup pal1/idx3 before frame_start → FE06FF. After frame_start → 0x8F4D2A with transparent=0, and pending clears.
- Write and frame_start in the same cycle with pending set, new value 0x123456 → active holds the old shadow value. A second commit+frame_start yields 0x123456.
- NUM_PAL=3, lookup pix_pal=3 → FE06FF, transparent=1. Write with wr_pal=3 → no table change.
- Back-to-back lookups for 16 cycles across indices 0..15 → 16 consecutive out_valid with correct ordering. Reset asserted mid-stream → outputs zero immediately.
- With SPRITE_PAL_FADE_EN, entry 0xCB6C3D at fade_lvl=4 → 0x65361E after 3 cycles, transparent=0.
